// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter sharing one combinational ALU
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_aluop,
    input  logic [5:0]       req0_funct,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_aluop,
    input  logic [5:0]       req1_funct,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_aluop,
    output logic [5:0]       alu_funct,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             busy,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q,       state_d;
    logic             last_grant_q,  last_grant_d;
    logic             id_q,          id_d;
    logic [WIDTH-1:0] alu_a_q,       alu_a_d;
    logic [WIDTH-1:0] alu_b_q,       alu_b_d;
    logic [2:0]       alu_aluop_q,   alu_aluop_d;
    logic [5:0]       alu_funct_q,   alu_funct_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic             rsp0_zero_q,   rsp0_zero_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic             rsp1_zero_q,   rsp1_zero_d;
    logic [15:0]      op_count_q,    op_count_d;

    logic             grant_valid;
    logic             grant_id;

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Next-state logic: issue on accept, capture ALU output in EXEC, count in RESP.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_aluop_d   = alu_aluop_q;
        alu_funct_d   = alu_funct_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        op_count_d    = op_count_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d      = EXEC;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    if (grant_id) begin
                        alu_a_d     = req1_a;
                        alu_b_d     = req1_b;
                        alu_aluop_d = req1_aluop;
                        alu_funct_d = req1_funct;
                    end else begin
                        alu_a_d     = req0_a;
                        alu_b_d     = req0_b;
                        alu_aluop_d = req0_aluop;
                        alu_funct_d = req0_funct;
                    end
                end
            end
            EXEC: begin
                state_d = RESP;
                if (id_q) begin
                    rsp1_result_d = alu_result;
                    rsp1_zero_d   = alu_zero;
                end else begin
                    rsp0_result_d = alu_result;
                    rsp0_zero_d   = alu_zero;
                end
            end
            RESP: begin
                state_d    = IDLE;
                op_count_d = op_count_q + 16'd1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset forces everything back to idle and zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_aluop_q   <= '0;
            alu_funct_q   <= '0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_aluop_q   <= alu_aluop_d;
            alu_funct_q   <= alu_funct_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
            op_count_q    <= op_count_d;
        end
    end

    // Output decode: ready only in IDLE for the winner, response pulse only in RESP.
    always_comb begin
        req0_ready  = grant_valid && !grant_id;
        req1_ready  = grant_valid &&  grant_id;
        rsp0_valid  = (state_q == RESP) && !id_q;
        rsp1_valid  = (state_q == RESP) &&  id_q;
        rsp0_result = rsp0_result_q;
        rsp0_zero   = rsp0_zero_q;
        rsp1_result = rsp1_result_q;
        rsp1_zero   = rsp1_zero_q;
        alu_a       = alu_a_q;
        alu_b       = alu_b_q;
        alu_aluop   = alu_aluop_q;
        alu_funct   = alu_funct_q;
        busy        = (state_q != IDLE);
        op_count    = op_count_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_aluop, req1_aluop;
    logic [5:0]  req0_funct, req1_funct;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_aluop;
    logic [5:0]  alu_funct;
    logic        alu_zero;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_aluop  (req0_aluop),
        .req0_funct  (req0_funct),
        .req0_ready  (req0_ready),
        .rsp0_valid  (rsp0_valid),
        .rsp0_result (rsp0_result),
        .rsp0_zero   (rsp0_zero),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_aluop  (req1_aluop),
        .req1_funct  (req1_funct),
        .req1_ready  (req1_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_result (rsp1_result),
        .rsp1_zero   (rsp1_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_aluop   (alu_aluop),
        .alu_funct   (alu_funct),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .busy        (busy),
        .op_count    (op_count)
    );

    // Reference ALU: R-type add/sub/and/or, I-type add, J-type subtract.
    always_comb begin
        alu_result = 32'd0;
        case (alu_aluop)
            3'b010: begin
                case (alu_funct)
                    6'b100000: alu_result = alu_a + alu_b;
                    6'b100010: alu_result = alu_a - alu_b;
                    6'b100100: alu_result = alu_a & alu_b;
                    6'b100101: alu_result = alu_a | alu_b;
                    default:   alu_result = 32'd0;
                endcase
            end
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_aluop = '0; req0_funct = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_aluop = '0; req1_funct = '0;

        // Reset state
        #2;
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_ready0",   32'(req0_ready),  32'd0);
        chk("rst_rsp0_v",   32'(rsp0_valid),  32'd0);
        chk("rst_alu_a",    alu_a,            32'd0);
        chk("rst_op_count", 32'(op_count),    32'd0);
        chk("rst_rsp1_res", rsp1_result,      32'd0);

        // Single op from req0, accepted on first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_aluop = 3'b010; req0_funct = 6'b100000;
        #1;
        chk("single_ready0", 32'(req0_ready), 32'd1);
        chk("single_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("single_exec_busy",  32'(busy),       32'd1);
        chk("single_exec_rdy",   32'(req0_ready), 32'd0);
        chk("single_exec_alu_a", alu_a,           32'd5);
        chk("single_exec_alu_b", alu_b,           32'd3);
        chk("single_exec_rsp_v", 32'(rsp0_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("single_rsp0_v",   32'(rsp0_valid), 32'd1);
        chk("single_rsp0_res", rsp0_result,     32'd8);
        chk("single_rsp0_z",   32'(rsp0_zero),  32'd0);
        chk("single_rsp1_v",   32'(rsp1_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("single_after_v",  32'(rsp0_valid), 32'd0);
        chk("single_after_bz", 32'(busy),       32'd0);
        chk("single_count",    32'(op_count),   32'd1);
        chk("single_hold_a",   alu_a,           32'd5);

        // Re-reset, then tie: grants alternate 0,1,0,1 every three cycles
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rerst_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_aluop = 3'b010; req0_funct = 6'b100000;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_aluop = 3'b001; req1_funct = 6'b000000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_ready0", 32'(req0_ready), ((k % 2) == 0) ? 32'd1 : 32'd0);
            chk("tie_ready1", 32'(req1_ready), ((k % 2) == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
            #1;
            chk("tie_exec_ready", 32'(req0_ready | req1_ready), 32'd0);
            @(negedge clk);
            #1;
            chk("tie_resp_ready", 32'(req0_ready | req1_ready), 32'd0);
            if ((k % 2) == 0) begin
                chk("tie_rsp0_v",   32'(rsp0_valid), 32'd1);
                chk("tie_rsp0_res", rsp0_result,     32'd13);
            end else begin
                chk("tie_rsp1_v",   32'(rsp1_valid), 32'd1);
                chk("tie_rsp1_res", rsp1_result,     32'd7);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("tie_count", 32'(op_count), 32'd4);

        // Subtract to zero on req1
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_aluop = 3'b010; req1_funct = 6'b100010;
        #1;
        chk("sub_ready1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("sub_exec_funct", 32'(alu_funct), 32'h22);
        @(negedge clk);
        #1;
        chk("sub_rsp1_v",    32'(rsp1_valid), 32'd1);
        chk("sub_rsp1_res",  rsp1_result,     32'd0);
        chk("sub_rsp1_z",    32'(rsp1_zero),  32'd1);
        chk("sub_rsp0_v",    32'(rsp0_valid), 32'd0);
        chk("sub_rsp0_hold", rsp0_result,     32'd13);
        @(negedge clk);
        #1;
        chk("sub_count", 32'(op_count), 32'd5);

        // Reset in the middle of EXEC
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_aluop = 3'b010; req0_funct = 6'b100000;
        #1;
        chk("mid_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("mid_exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_alu_a", alu_a,          32'd0);
        chk("mid_rst_funct", 32'(alu_funct), 32'd0);
        chk("mid_rst_res0",  rsp0_result,    32'd0);
        chk("mid_rst_z1",    32'(rsp1_zero), 32'd0);
        chk("mid_rst_count", 32'(op_count),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("mid_count_after", 32'(op_count), 32'd0);

        // Withdrawal: req1 raises valid only while busy and drops before IDLE
        req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd22; req0_aluop = 3'b000; req0_funct = 6'b111111;
        #1;
        chk("wd_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd99; req1_b = 32'd1; req1_aluop = 3'b010; req1_funct = 6'b100000;
        #1;
        chk("wd_exec_ready1", 32'(req1_ready), 32'd0);
        chk("wd_exec_funct",  32'(alu_funct),  32'h3f);
        @(negedge clk);
        #1;
        chk("wd_rsp0_v",   32'(rsp0_valid), 32'd1);
        chk("wd_rsp0_res", rsp0_result,     32'd42);
        chk("wd_ready1",   32'(req1_ready), 32'd0);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("wd_idle_ready1", 32'(req1_ready), 32'd0);
        chk("wd_idle_alu_a",  alu_a,           32'd20);
        @(negedge clk);
        #1;
        chk("wd_no_busy",  32'(busy),       32'd0);
        chk("wd_no_rsp1",  32'(rsp1_valid), 32'd0);
        chk("wd_hold_a",   alu_a,           32'd20);
        chk("wd_count",    32'(op_count),   32'd1);

        // Counter wrap from FFFF to 0000
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        #1;
        chk("wrap_preload", 32'(op_count), 32'h0000ffff);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_aluop = 3'b010; req0_funct = 6'b100000;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("wrap_resp_res",   rsp0_result,     32'd2);
        chk("wrap_resp_count", 32'(op_count),   32'h0000ffff);
        @(negedge clk);
        #1;
        chk("wrap_count", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have, per requester i in {0,1}: reqi_valid  input  1  request present.
REQ-005 SHALL have reqi_a, reqi_b  input  WIDTH  operands.
REQ-006 SHALL have reqi_aluop  input  3  ALUOp code (010 R-type, 000 I-type, 001 J-type).
REQ-007 SHALL have reqi_funct  input  6  R-type function field.
REQ-008 SHALL have reqi_ready  output  1  request accepted this cycle when high with reqi_valid.
REQ-009 SHALL have rspi_valid  output  1  one-cycle result pulse.
REQ-010 SHALL have rspi_result  output  WIDTH and rspi_zero  output  1: returned ALU result and zero flag.
REQ-011 SHALL have alu_a, alu_b  output  WIDTH; alu_aluop  output  3; alu_funct  output  6: drive the shared ALU and its ALU_control.
REQ-012 SHALL have alu_result  input  WIDTH and alu_zero  input  1: combinational ALU response.
REQ-013 SHALL have busy  output  1 (state not IDLE) and op_count  output  16 (completed operations).

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 In IDLE, SHALL assert reqi_ready combinationally only for the requester selected by arbitration; at most one ready high per cycle.
REQ-016 Arbitration: only one valid -> grant it; both valid -> grant requester not equal to last_grant register; none valid -> no grant.
REQ-017 On accept (valid & ready), SHALL load alu_a/alu_b/alu_aluop/alu_funct from the granted requester, record granted id, update last_grant, go to EXEC.
REQ-018 In EXEC, SHALL hold alu_* stable, sample alu_result/alu_zero at end of cycle into the response register of the recorded requester, go to RESP.
REQ-019 In RESP, SHALL assert rspi_valid for the recorded requester only, for exactly one cycle; return to IDLE; increment op_count (mod 2^16, FFFF wraps to 0000).
REQ-020 Latency: accept in cycle N -> rspi_valid in cycle N+2; throughput one operation per 3 cycles; reqi_ready low in EXEC and RESP.
REQ-021 rspi_result/rspi_zero SHALL hold last captured value for that requester until its next capture.
REQ-022 Responses SHALL have no backpressure; requesters must sample on rspi_valid.
REQ-023 A requester may drop reqi_valid before acceptance; no state change results.
REQ-024 alu_* outputs SHALL hold last issued values in IDLE (no toggling without a grant).
REQ-025 Arbiter SHALL not decode aluop/funct; unsupported codes pass through unchanged.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, last_grant=1 (requester 0 wins first tie), all reqi_ready/rspi_valid=0, rspi_result=0, rspi_zero=0, alu_*=0, op_count=0, busy=0.
REQ-027 Reset during EXEC or RESP SHALL abort the operation: no response pulse, op_count not incremented.
REQ-028 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 Single: req0 a=5 b=3 aluop=010 funct=100000, ALU model returns 8 -> req0_ready cycle N, rsp0_valid N+2, rsp0_result=8, rsp0_zero=0, op_count=1.
REQ-030 Tie after reset: both valid every cycle -> grants alternate 0,1,0,1 at cycles N, N+3, N+6, N+9; never both ready.
REQ-031 Subtract to zero: req1 a=b=7 funct=100010 -> alu_funct=100010 during EXEC, rsp1_result=0, rsp1_zero=1, rsp0_valid stays 0.
REQ-032 Reset mid-EXEC: assert rst_n low in EXEC -> all outputs zero asynchronously, no rsp pulse after release, op_count=0.
REQ-033 Wrap: preload 65535 completions (or force) then one op -> op_count=0000.
REQ-034 Withdrawal: req1 valid only while busy, dropped before IDLE -> no grant, no rsp1_valid, alu_* unchanged.
